// File: rtl/uart_core.sv
// Full-duplex UART. The receiver oversamples 16x and takes a 2-of-3 vote at mid-bit.
// Received words go into a show-ahead FIFO, each tagged with its parity and framing error flags.
module uart_core #(
   parameter int P_SYSTEM_CLK     = 50_000_000,
   parameter int P_UART_BUADRATE  = 9600,
   parameter int P_UART_DATAWIDTH = 8,
   parameter int P_UART_STOPWIDTH = 1,
   parameter int P_UART_PARITY    = 0,
   parameter int P_RX_FIFO_DEPTH  = 16
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_uart_rx,
   output logic                        o_uart_tx,
   input  logic [P_UART_DATAWIDTH-1:0] i_user_tx_data,
   input  logic                        i_user_tx_valid,
   output logic                        o_user_tx_ready,
   output logic [P_UART_DATAWIDTH-1:0] o_user_rx_data,
   output logic                        o_user_rx_parity_err,
   output logic                        o_user_rx_frame_err,
   output logic                        o_user_rx_valid,
   input  logic                        i_user_rx_ready,
   output logic                        o_rx_overflow
);
   // state    | meaning
   // S_IDLE   | line idle, waiting for a low level
   // S_START  | start bit, false start rejected at mid-bit
   // S_DATA   | shifting in data bits, LSB first
   // S_PARITY | parity bit (never entered when parity is off)
   // S_STOP   | stop bit(s); word pushed at mid-bit of the last one

   localparam int DIV = P_SYSTEM_CLK / (P_UART_BUADRATE * 16);
   localparam int DW  = P_UART_DATAWIDTH;
   localparam int PB  = (P_UART_PARITY != 0) ? 1 : 0;
   localparam int NB  = DW + PB + P_UART_STOPWIDTH;
   localparam int AW  = (P_RX_FIFO_DEPTH > 1) ? $clog2(P_RX_FIFO_DEPTH) : 1;
   localparam int DVW = (DIV > 1) ? $clog2(DIV) : 1;

   if (DIV < 1) begin : g_div_chk
      $error("uart_core: system clock too slow for 16x oversampling at this baud rate");
   end

   function automatic logic par_bit(input logic [DW-1:0] d);
      par_bit = (P_UART_PARITY == 1) ? ~^d : ^d;
   endfunction

   logic [DVW-1:0] div_cnt;
   logic           tick;

   assign tick = (div_cnt == '0);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)    div_cnt <= '0;
      else if (tick) div_cnt <= DVW'(DIV - 1);
      else           div_cnt <= div_cnt - 1'b1;
   end

   logic [NB-1:0] tx_frame, tx_shift;
   logic [3:0]    tx_tcnt, tx_left;

   always_comb begin
      tx_frame           = '1;
      tx_frame[DW-1:0]   = i_user_tx_data;
      if (PB == 1) tx_frame[DW] = par_bit(i_user_tx_data);
   end

   // tx_left counts the bits still to go after the start bit
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_uart_tx       <= 1'b1;
         o_user_tx_ready <= 1'b1;
         tx_shift        <= '1;
         tx_tcnt         <= '0;
         tx_left         <= '0;
      end else if (o_user_tx_ready) begin
         if (i_user_tx_valid) begin
            o_user_tx_ready <= 1'b0;
            o_uart_tx       <= 1'b0;
            tx_shift        <= tx_frame;
            tx_tcnt         <= '0;
            tx_left         <= 4'(NB);
         end
      end else if (tick) begin
         tx_tcnt <= tx_tcnt + 4'd1;
         if (tx_tcnt == 4'd15) begin
            if (tx_left == '0) begin
               o_user_tx_ready <= 1'b1;
               o_uart_tx       <= 1'b1;
            end else begin
               o_uart_tx <= tx_shift[0];
               tx_shift  <= {1'b1, tx_shift[NB-1:1]};
               tx_left   <= tx_left - 4'd1;
            end
         end
      end
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} rx_state_t;
   rx_state_t rx_state, rx_next;

   logic [1:0]    rx_sync, rx_smp;
   logic          rx_s, rx_maj, rx_mid, rx_end, rx_last_stop, rx_push;
   logic [3:0]    rx_tcnt, rx_bidx;
   logic          rx_stop_idx, rx_perr, rx_ferr;
   logic [DW-1:0] rx_shift;

   assign rx_s         = rx_sync[1];
   assign rx_maj       = (rx_smp[1] & rx_smp[0]) | (rx_smp[1] & rx_s) | (rx_smp[0] & rx_s);
   assign rx_mid       = tick && (rx_tcnt == 4'd9);
   assign rx_end       = tick && (rx_tcnt == 4'd15);
   assign rx_last_stop = (rx_stop_idx == 1'(P_UART_STOPWIDTH - 1));

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         rx_sync  <= 2'b11;
         rx_state <= S_IDLE;
      end else begin
         rx_sync  <= {rx_sync[0], i_uart_rx};
         rx_state <= rx_next;
      end
   end

   always_comb begin
      rx_next = rx_state;
      rx_push = 1'b0;
      case (rx_state)
         S_IDLE:   if (!rx_s) rx_next = S_START;
         S_START: begin
            if (rx_mid && rx_maj) rx_next = S_IDLE;
            else if (rx_end)      rx_next = S_DATA;
         end
         S_DATA:   if (rx_end && rx_bidx == 4'(DW - 1)) rx_next = (PB == 1) ? S_PARITY : S_STOP;
         S_PARITY: if (rx_end) rx_next = S_STOP;
         S_STOP: begin
            if (rx_mid && rx_last_stop) begin
               rx_push = 1'b1;
               rx_next = S_IDLE;
            end
         end
         default:  rx_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         rx_tcnt     <= '0;
         rx_bidx     <= '0;
         rx_smp      <= 2'b11;
         rx_shift    <= '0;
         rx_stop_idx <= 1'b0;
         rx_perr     <= 1'b0;
         rx_ferr     <= 1'b0;
      end else if (rx_state == S_IDLE) begin
         rx_tcnt     <= '0;
         rx_bidx     <= '0;
         rx_stop_idx <= 1'b0;
         rx_perr     <= 1'b0;
         rx_ferr     <= 1'b0;
      end else if (tick) begin
         rx_tcnt <= rx_tcnt + 4'd1;
         if (rx_tcnt == 4'd7 || rx_tcnt == 4'd8) rx_smp <= {rx_smp[0], rx_s};
         if (rx_tcnt == 4'd9) begin
            case (rx_state)
               S_DATA:   rx_shift <= {rx_maj, rx_shift[DW-1:1]};
               S_PARITY: rx_perr  <= (rx_maj != par_bit(rx_shift));
               S_STOP:   if (!rx_maj) rx_ferr <= 1'b1;
               default:  ;
            endcase
         end
         if (rx_tcnt == 4'd15) begin
            if (rx_state == S_DATA) rx_bidx     <= rx_bidx + 4'd1;
            if (rx_state == S_STOP) rx_stop_idx <= ~rx_stop_idx;
         end
      end
   end

   logic [DW+1:0] fifo_mem [P_RX_FIFO_DEPTH];
   logic [DW+1:0] fifo_wdata, fifo_head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   fifo_cnt;
   logic          fifo_pop, fifo_full, push_ok;

   // frame_err folds in the vote of the final stop bit, which is taken in the same cycle as the push
   assign fifo_wdata = {rx_perr, rx_ferr | ~rx_maj, rx_shift};
   assign fifo_full  = (fifo_cnt == (AW+1)'(P_RX_FIFO_DEPTH));
   assign fifo_pop   = o_user_rx_valid && i_user_rx_ready;
   assign push_ok    = rx_push && (!fifo_full || fifo_pop);
   assign fifo_head  = fifo_mem[rd_ptr];

   always_ff @(posedge i_clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= fifo_wdata;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_cnt      <= '0;
         o_rx_overflow <= 1'b0;
      end else begin
         o_rx_overflow <= rx_push && fifo_full && !fifo_pop;
         if (push_ok)  wr_ptr <= wr_ptr + 1'b1;
         if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, fifo_pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   assign o_user_rx_valid      = (fifo_cnt != '0);
   assign o_user_rx_data       = o_user_rx_valid ? fifo_head[DW-1:0] : '0;
   assign o_user_rx_frame_err  = o_user_rx_valid & fifo_head[DW];
   assign o_user_rx_parity_err = o_user_rx_valid & fifo_head[DW+1];

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: one instance with even parity, 1 stop bit and a depth-4 FIFO driven from the bench;
// a second instance with odd parity and 2 stop bits, looped back tx to rx.
module tb_uart_core;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_e, rx_e, tx_e, txv_e, txr_e, rxpe_e, rxfe_e, rxv_e, rxr_e, ovf_e;
   logic [7:0] txd_e, rxd_e;
   logic       rst_o, tx_o, txv_o, txr_o, rxpe_o, rxfe_o, rxv_o, rxr_o, ovf_o;
   logic [7:0] txd_o, rxd_o;

   uart_core #(.P_SYSTEM_CLK(16_000_000), .P_UART_BUADRATE(1_000_000), .P_UART_DATAWIDTH(8),
               .P_UART_STOPWIDTH(1), .P_UART_PARITY(2), .P_RX_FIFO_DEPTH(4)) dut_e (
      .i_clk(clk), .i_rst(rst_e), .i_uart_rx(rx_e), .o_uart_tx(tx_e),
      .i_user_tx_data(txd_e), .i_user_tx_valid(txv_e), .o_user_tx_ready(txr_e),
      .o_user_rx_data(rxd_e), .o_user_rx_parity_err(rxpe_e), .o_user_rx_frame_err(rxfe_e),
      .o_user_rx_valid(rxv_e), .i_user_rx_ready(rxr_e), .o_rx_overflow(ovf_e));

   uart_core #(.P_SYSTEM_CLK(16_000_000), .P_UART_BUADRATE(1_000_000), .P_UART_DATAWIDTH(8),
               .P_UART_STOPWIDTH(2), .P_UART_PARITY(1), .P_RX_FIFO_DEPTH(16)) dut_o (
      .i_clk(clk), .i_rst(rst_o), .i_uart_rx(tx_o), .o_uart_tx(tx_o),
      .i_user_tx_data(txd_o), .i_user_tx_valid(txv_o), .o_user_tx_ready(txr_o),
      .o_user_rx_data(rxd_o), .o_user_rx_parity_err(rxpe_o), .o_user_rx_frame_err(rxfe_o),
      .o_user_rx_valid(rxv_o), .i_user_rx_ready(rxr_o), .o_rx_overflow(ovf_o));

   typedef struct packed {logic [7:0] d; logic pe; logic fe;} exp_t;
   exp_t q_e[$], q_o[$];
   exp_t xe, xo;
   int   n_cmp = 0, n_bad = 0, ovf_cnt_e = 0, ovf_cnt_o = 0;

   function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic fe);
      exp_t r;
      r.d = d; r.pe = pe; r.fe = fe;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // scoreboard monitors: pop one expected word per accepted head word
   always @(negedge clk) begin
      if (ovf_e) ovf_cnt_e++;
      if (ovf_o) ovf_cnt_o++;
      if (rxv_e && rxr_e) begin
         if (q_e.size() == 0) chk("rx_e_unexpected_word", {22'd0, rxpe_e, rxfe_e, rxd_e}, 32'hDEAD);
         else begin
            xe = q_e.pop_front();
            chk("rx_e_data", rxd_e, xe.d);
            chk("rx_e_parity_err", rxpe_e, xe.pe);
            chk("rx_e_frame_err", rxfe_e, xe.fe);
         end
      end
      if (rxv_o && rxr_o) begin
         if (q_o.size() == 0) chk("rx_o_unexpected_word", {22'd0, rxpe_o, rxfe_o, rxd_o}, 32'hDEAD);
         else begin
            xo = q_o.pop_front();
            chk("rx_o_data", rxd_o, xo.d);
            chk("rx_o_parity_err", rxpe_o, xo.pe);
            chk("rx_o_frame_err", rxfe_o, xo.fe);
         end
      end
   end

   task automatic send_e(input logic [7:0] d, input logic bad_par, input logic bad_stop);
      logic [10:0] f;
      f = {~bad_stop, (^d) ^ bad_par, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         rx_e = f[i];
         repeat (16) @(posedge clk);
         #1;
      end
      rx_e = 1'b1;
      repeat (32) @(posedge clk);
      #1;
   endtask

   initial begin
      #400_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] fa5;
      logic [10:0] fb;
      logic [7:0]  lb [3];
      int          n;
      lb = '{8'h00, 8'hFF, 8'h3C};
      rst_e = 1'b0; rst_o = 1'b0; rx_e = 1'b1;
      txv_e = 1'b0; txd_e = '0; rxr_e = 1'b1;
      txv_o = 1'b0; txd_o = '0; rxr_o = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx_line", tx_e, 1);
      chk("rst_tx_ready", txr_e, 1);
      chk("rst_rx_valid", rxv_e, 0);
      chk("rst_rx_data", rxd_e, 0);
      chk("rst_rx_perr", rxpe_e, 0);
      chk("rst_rx_ferr", rxfe_e, 0);
      chk("rst_overflow", ovf_e, 0);
      chk("rst_tx_line_o", tx_o, 1);
      chk("rst_rx_valid_o", rxv_o, 0);
      rst_e = 1'b1; rst_o = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // TX 0xA5, even parity: 0,1,0,1,0,0,1,0,1,0,1; valid pulsed mid-frame must be ignored
      fa5 = {1'b1, 1'b0, 8'hA5, 1'b0};
      txd_e = 8'hA5; txv_e = 1'b1;
      @(posedge clk);
      #1;
      txv_e = 1'b0;
      for (int k = 0; k < 176; k++) begin
         if (k == 50) begin txd_e = 8'hFF; txv_e = 1'b1; end
         if (k == 60) txv_e = 1'b0;
         chk("tx_line_a5", tx_e, fa5[k/16]);
         chk("tx_ready_low", txr_e, 0);
         @(posedge clk);
         #1;
      end
      chk("tx_ready_back", txr_e, 1);
      chk("tx_line_idle", tx_e, 1);

      // loopback, odd parity, 2 stop bits, back-to-back
      for (int w = 0; w < 3; w++) begin
         q_o.push_back(mk(lb[w], 1'b0, 1'b0));
         txd_o = lb[w]; txv_o = 1'b1;
         n = 0;
         while (!txr_o && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
         end
         chk("txr_o_wait_in_budget", (n < 1000), 1);
         @(posedge clk);
         #1;
      end
      txv_o = 1'b0;
      repeat (260) @(posedge clk);
      #1;
      chk("loopback_drained", q_o.size(), 0);

      // error flags: bad parity, then bad stop
      q_e.push_back(mk(8'h55, 1'b1, 1'b0));
      send_e(8'h55, 1'b1, 1'b0);
      q_e.push_back(mk(8'h55, 1'b0, 1'b1));
      send_e(8'h55, 1'b0, 1'b1);
      chk("err_words_drained", q_e.size(), 0);

      // overflow with a depth-4 FIFO
      rxr_e = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         if (i <= 4) q_e.push_back(mk(8'(i), 1'b0, 1'b0));
         send_e(8'(i), 1'b0, 1'b0);
      end
      chk("overflow_pulse_cycles", ovf_cnt_e, 1);
      chk("full_valid", rxv_e, 1);
      chk("full_head", rxd_e, 8'h01);
      rxr_e = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("drained_valid", rxv_e, 0);
      chk("overflow_words_drained", q_e.size(), 0);

      // 5-clock low glitch must be rejected as a false start
      rx_e = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rx_e = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("glitch_no_push", rxv_e, 0);
      q_e.push_back(mk(8'h7E, 1'b0, 1'b0));
      send_e(8'h7E, 1'b0, 1'b0);
      chk("after_glitch_drained", q_e.size(), 0);

      // reset mid-tx-data and mid-rx-data, with a word held in the FIFO
      rxr_e = 1'b0;
      send_e(8'h11, 1'b0, 1'b0);
      chk("held_word_valid", rxv_e, 1);
      fb = {1'b1, ^8'h22, 8'h22, 1'b0};
      fork
         begin
            @(posedge clk);
            #1;
            txd_e = 8'h3C; txv_e = 1'b1;
            @(posedge clk);
            #1;
            txv_e = 1'b0;
         end
         begin
            for (int i = 0; i < 5; i++) begin
               rx_e = fb[i];
               repeat (16) @(posedge clk);
               #1;
            end
            rx_e = 1'b1;
         end
         begin
            repeat (41) @(posedge clk);
            @(negedge clk);
            chk("pre_rst_tx_data_bit", tx_e, 0);
            rst_e = 1'b0;
            #1;
            chk("mid_rst_tx_line", tx_e, 1);
            chk("mid_rst_tx_ready", txr_e, 1);
            chk("mid_rst_rx_valid", rxv_e, 0);
            chk("mid_rst_rx_data", rxd_e, 0);
         end
      join
      repeat (5) @(posedge clk);
      #1;
      rst_e = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      rxr_e = 1'b1;
      q_e.push_back(mk(8'h96, 1'b0, 1'b0));
      send_e(8'h96, 1'b0, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      chk("post_rst_drained", q_e.size(), 0);
      chk("loopback_no_overflow", ovf_cnt_o, 0);
      chk("final_q_o_empty", q_o.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
